fwd_pipe: RTL and testbench
===========================

FWD_PIPE -- requirements
Module: fwd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the data word width (matches word_t).
REQ-002 SHALL have parameter RADDR, default 5, meaning the register address width (matches creg_addr_t).
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode offers an instruction.
- issue_dst  in  RADDR  destination register.
- issue_wen  in  1  the instruction writes a register.
- issue_ismem  in  1  the instruction is a load.
- issue_ready  out  1  the E slot accepts the offered instruction this cycle.
- flush  in  1  kill the E slot.
- exe_result  in  WIDTH  ALU result of the instruction in E (combinational input).
- mem_rdata  in  WIDTH  load data.
- mem_rdata_valid  in  1  mem_rdata is valid this cycle.
- dstE  out  RADDR  forwarding tag for the E slot.
- validE  out  1  forwarding valid for the E slot.
- ismemE  out  1  the E slot holds a load.
- rdE  out  WIDTH  forwarded E value.
- dstM  out  RADDR  forwarding tag for the M slot.
- validM  out  1  forwarding valid for the M slot.
- rdM  out  WIDTH  forwarded M value.
- wb_valid  out  1  write-back enable.
- wb_dst  out  RADDR  write-back register.
- wb_data  out  WIDTH  write-back data.

Function
REQ-004 SHALL hold three slots, each with its own fields:
- E slot: v, dst, wen, ismem.
- M slot: v, dst, wen, ismem, done, data.
- W slot: v, dst, data.
REQ-005 SHALL compute m_wait = M.v && M.ismem && !M.done, combinationally.
REQ-006 SHALL drive issue_ready = !m_wait && !flush.
REQ-007 When !m_wait, on each edge SHALL move E to M and load M.data with exe_result.
REQ-008 On that move SHALL set M.done = !E.ismem.
REQ-009 On that same edge SHALL load E from issue when issue_valid && issue_ready, otherwise clear E.v.
REQ-010 When m_wait, SHALL hold both E and M unchanged and SHALL ignore issue.
REQ-011 When m_wait && mem_rdata_valid, SHALL load M.data with mem_rdata and set M.done = 1 on the edge.
REQ-012 The load SHALL leave M on the following non-waiting edge, giving one cycle of forwarding from M.
REQ-013 mem_rdata_valid SHALL be ignored when !m_wait.
REQ-014 W SHALL capture M (v && wen && dst != 0, dst, data) on every non-waiting edge.
REQ-015 W.v SHALL be cleared on every waiting edge, so a held M is written back exactly once.
REQ-016 flush SHALL clear E.v on the edge, taking priority over a simultaneous issue.
REQ-017 When flush and m_wait are both asserted, flush SHALL still clear E.v and M SHALL continue waiting.
REQ-018 Forwarding outputs SHALL be combinational from the slots:
- validE = E.v && E.wen && E.dst != 0; dstE = E.dst; ismemE = E.ismem; rdE = exe_result.
- validM = M.v && M.wen && M.dst != 0 && M.done; dstM = M.dst; rdM = M.data.
REQ-019 Latency SHALL be issue accepted at edge n, in E during cycle n+1, in M at n+2, and wb_valid at n+3 with no load wait.
REQ-020 A load in M waiting k cycles SHALL delay all later stages by exactly k cycles.
REQ-021 wb_valid, wb_dst and wb_data SHALL be registered outputs, driven directly from the W slot.

Reset
REQ-022 On resetn low, SHALL asynchronously clear E.v, M.v, M.done and W.v, and zero all dst and data fields.
REQ-023 During reset all valid outputs SHALL be 0, issue_ready SHALL be 1 and the data outputs SHALL be 0.
REQ-024 Reset asserted mid-load-wait SHALL abandon the load with no write-back after release.

Structure
REQ-025 The slot record types (e_slot_t, m_slot_t, w_slot_t) SHALL live in the shared pipes package.
REQ-026 word_t and creg_addr_t SHALL come from the common package.
REQ-027 One sub-module, fwd_slot_reg, SHALL implement a generic register with async active-low reset, hold enable and clear.
REQ-028 E, M and W SHALL each be an instance of fwd_slot_reg.

Verification
REQ-029 Case 1: issue dst=3, wen=1, exe_result=0x11, then idle.
- Required: validE=1, dstE=3 for one cycle.
- Then validM=1, rdM=0x11.
- Then wb_valid=1, wb_dst=3, wb_data=0x11, then all outputs zero.
REQ-030 Case 2: issue a load to dst=5 with mem_rdata_valid asserted 3 cycles after it enters M, mem_rdata=0xAB, and a second issue offered meanwhile.
- Required: issue_ready=0 and validM=0 for 3 cycles.
- Then validM=1, rdM=0xAB for one cycle.
- wb_data=0xAB is written exactly once.
- The second instruction enters E only after the wait ends.
REQ-031 Case 3: issue to dst=0 with wen=1.
- Required: validE, validM and wb_valid all stay 0.
REQ-032 Case 4: flush and issue_valid together while E holds dst=7.
- Required: issue_ready=0, E is cleared, nothing reaches write-back for dst 7 or the new issue.
REQ-033 Case 5: flush during a load wait.
- Required: E is cleared and M still completes when rdata arrives.
REQ-034 Case 6: resetn low mid-wait, then released.
- Required: outputs are 0 immediately (asynchronously) and no write-back occurs.
- The first post-reset issue flows normally.

Source files
------------

// File: rtl/fwd_pipe_pkg.sv
// ---------------------------------------------------------------------------
// Shared type definitions for the forwarding pipeline.
//
// common_pkg   : machine-wide word and register-address types.
// fwd_pipe_pkg : slot records for the E, M and W stages, plus a helper that
//                forms a forwarding-valid bit from a slot's fields.
//
// No ports (packages only).
// ---------------------------------------------------------------------------
package common_pkg;

  localparam int WORD_W      = 64;
  localparam int CREG_ADDR_W = 5;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [CREG_ADDR_W-1:0] creg_addr_t;

endpackage : common_pkg

package fwd_pipe_pkg;

  import common_pkg::*;

  // Execute slot: the instruction whose ALU result is being produced this
  // cycle. Its data is not stored; it is the live exe_result input.
  typedef struct packed {
    logic       v;
    creg_addr_t dst;
    logic       wen;
    logic       ismem;
  } e_slot_t;

  // Memory slot: done is low while a load is still waiting for its data.
  typedef struct packed {
    logic       v;
    creg_addr_t dst;
    logic       wen;
    logic       ismem;
    logic       done;
    word_t      data;
  } m_slot_t;

  // Write-back slot: v already folds in wen and the r0 exclusion.
  typedef struct packed {
    logic       v;
    creg_addr_t dst;
    word_t      data;
  } w_slot_t;

  localparam int E_SLOT_W = $bits(e_slot_t);
  localparam int M_SLOT_W = $bits(m_slot_t);
  localparam int W_SLOT_W = $bits(w_slot_t);

  // Register 0 is hard-wired, so a write to it is never forwarded or retired.
  function automatic logic fwd_tag_valid(input logic v, input logic wen,
                                         input creg_addr_t dst);
    return v && wen && (dst != '0);
  endfunction

endpackage : fwd_pipe_pkg

// File: rtl/fwd_pipe_slot_reg.sv
// ---------------------------------------------------------------------------
// fwd_slot_reg -- generic pipeline slot register.
//
// Holds a W-bit record. clr has priority and zeroes the whole record; en loads
// d; with neither asserted the record holds. Asynchronous active-low reset
// zeroes the record.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   en     in  1  load d on the next edge
//   clr    in  1  zero the record on the next edge (wins over en)
//   d      in  W  next record value
//   q      out W  current record value
// ---------------------------------------------------------------------------
module fwd_slot_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] rec_q;
  logic [W-1:0] rec_d;

  always_comb begin
    rec_d = rec_q;
    if (clr) begin
      rec_d = '0;
    end else if (en) begin
      rec_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign q = rec_q;

endmodule : fwd_slot_reg

// File: rtl/fwd_pipe.sv
// ---------------------------------------------------------------------------
// fwd_pipe -- three-slot (E, M, W) result-forwarding pipeline tracker.
//
// Tracks the destination tags and data of instructions in execute, memory and
// write-back so decode can forward operands, and retires results to the
// register file. A load sitting in M without its data stalls E and M; W sees
// a bubble for every stalled edge so the load retires exactly once.
//
// Issue handshake: an instruction is transferred on a rising edge where
// issue_valid && issue_ready are both high. issue_ready does not depend on
// issue_valid; the offerer may hold or change its offer freely while
// issue_ready is low, and nothing is consumed on such an edge.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   issue_valid/_dst/_wen/_ismem, issue_ready   instruction offer into E
//   flush                  kill the instruction in E (wins over issue)
//   exe_result             ALU result of the instruction in E (combinational)
//   mem_rdata, mem_rdata_valid                  load data for a waiting M
//   dstE/validE/ismemE/rdE forwarding view of E
//   dstM/validM/rdM        forwarding view of M
//   wb_valid/wb_dst/wb_data                     registered write-back from W
//
// WIDTH and RADDR must equal the common word_t / creg_addr_t widths; the slot
// records are built from those types.
// ---------------------------------------------------------------------------
module fwd_pipe
  import common_pkg::*;
  import fwd_pipe_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int RADDR = CREG_ADDR_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_valid,
  input  logic [RADDR-1:0] issue_dst,
  input  logic             issue_wen,
  input  logic             issue_ismem,
  output logic             issue_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] exe_result,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rdata_valid,
  output logic [RADDR-1:0] dstE,
  output logic             validE,
  output logic             ismemE,
  output logic [WIDTH-1:0] rdE,
  output logic [RADDR-1:0] dstM,
  output logic             validM,
  output logic [WIDTH-1:0] rdM,
  output logic             wb_valid,
  output logic [RADDR-1:0] wb_dst,
  output logic [WIDTH-1:0] wb_data
);

  e_slot_t e_q, e_d;
  m_slot_t m_q, m_d;
  w_slot_t w_q, w_d;

  logic e_en, e_clr;
  logic m_en;
  logic w_clr;

  logic m_wait;
  logic issue_fire;

  // -------------------------------------------------------------------------
  // Stall and handshake
  // -------------------------------------------------------------------------
  assign m_wait      = m_q.v && m_q.ismem && !m_q.done;
  assign issue_ready = !m_wait && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  // -------------------------------------------------------------------------
  // E slot: loads from issue on an accepted offer. Otherwise it empties on
  // every advancing edge, and also on any flush edge even while M stalls.
  // -------------------------------------------------------------------------
  always_comb begin
    e_d       = '0;
    e_d.v     = 1'b1;
    e_d.dst   = issue_dst;
    e_d.wen   = issue_wen;
    e_d.ismem = issue_ismem;
    e_en      = issue_fire;
    e_clr     = flush || (!m_wait && !issue_fire);
  end

  // -------------------------------------------------------------------------
  // M slot: advances from E when not stalled. While stalled it only changes
  // when the load data arrives. A flushed E instruction moves in as a bubble
  // so it can never reach write-back.
  // -------------------------------------------------------------------------
  always_comb begin
    m_d  = m_q;
    m_en = 1'b0;
    if (m_wait) begin
      if (mem_rdata_valid) begin
        m_d.data = mem_rdata;
        m_d.done = 1'b1;
        m_en     = 1'b1;
      end
    end else begin
      m_d.v     = e_q.v && !flush;
      m_d.dst   = e_q.dst;
      m_d.wen   = e_q.wen;
      m_d.ismem = e_q.ismem;
      m_d.done  = !e_q.ismem;
      m_d.data  = exe_result;
      m_en      = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // W slot: samples M on every advancing edge; a stalled edge inserts a
  // bubble so a held load is retired only on the edge it leaves M.
  // -------------------------------------------------------------------------
  always_comb begin
    w_d      = '0;
    w_d.v    = fwd_tag_valid(m_q.v, m_q.wen, m_q.dst);
    w_d.dst  = m_q.dst;
    w_d.data = m_q.data;
    w_clr    = m_wait;
  end

  // -------------------------------------------------------------------------
  // Slot registers
  // -------------------------------------------------------------------------
  fwd_slot_reg #(.W(E_SLOT_W)) u_e_slot (
    .clk   (clk),
    .rst_n (resetn),
    .en    (e_en),
    .clr   (e_clr),
    .d     (e_d),
    .q     (e_q)
  );

  fwd_slot_reg #(.W(M_SLOT_W)) u_m_slot (
    .clk   (clk),
    .rst_n (resetn),
    .en    (m_en),
    .clr   (1'b0),
    .d     (m_d),
    .q     (m_q)
  );

  fwd_slot_reg #(.W(W_SLOT_W)) u_w_slot (
    .clk   (clk),
    .rst_n (resetn),
    .en    (1'b1),
    .clr   (w_clr),
    .d     (w_d),
    .q     (w_q)
  );

  // -------------------------------------------------------------------------
  // Forwarding and write-back outputs
  // -------------------------------------------------------------------------
  assign validE = fwd_tag_valid(e_q.v, e_q.wen, e_q.dst);
  assign dstE   = e_q.dst;
  assign ismemE = e_q.ismem;
  assign rdE    = exe_result;

  // A waiting load has no data yet, so it is not forwardable until done.
  assign validM = fwd_tag_valid(m_q.v, m_q.wen, m_q.dst) && m_q.done;
  assign dstM   = m_q.dst;
  assign rdM    = m_q.data;

  assign wb_valid = w_q.v;
  assign wb_dst   = w_q.dst;
  assign wb_data  = w_q.data;

endmodule : fwd_pipe

// File: tb/tb_fwd_pipe.sv
// ---------------------------------------------------------------------------
// Self-checking bench for fwd_pipe. Directed cases drive issue/flush/memory
// inputs and check the forwarding view on the falling edge; every expected
// write-back is queued when its instruction is offered and a separate monitor
// pops and compares whenever wb_valid is seen.
// ---------------------------------------------------------------------------
module tb_fwd_pipe;

  localparam int WIDTH = 64;
  localparam int RADDR = 5;

  logic             clk;
  logic             resetn;
  logic             issue_valid;
  logic [RADDR-1:0] issue_dst;
  logic             issue_wen;
  logic             issue_ismem;
  logic             issue_ready;
  logic             flush;
  logic [WIDTH-1:0] exe_result;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rdata_valid;
  logic [RADDR-1:0] dstE;
  logic             validE;
  logic             ismemE;
  logic [WIDTH-1:0] rdE;
  logic [RADDR-1:0] dstM;
  logic             validM;
  logic [WIDTH-1:0] rdM;
  logic             wb_valid;
  logic [RADDR-1:0] wb_dst;
  logic [WIDTH-1:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [RADDR+WIDTH-1:0] exp_q[$];

  fwd_pipe #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .issue_valid     (issue_valid),
    .issue_dst       (issue_dst),
    .issue_wen       (issue_wen),
    .issue_ismem     (issue_ismem),
    .issue_ready     (issue_ready),
    .flush           (flush),
    .exe_result      (exe_result),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .dstE            (dstE),
    .validE          (validE),
    .ismemE          (ismemE),
    .rdE             (rdE),
    .dstM            (dstM),
    .validM          (validM),
    .rdM             (rdM),
    .wb_valid        (wb_valid),
    .wb_dst          (wb_dst),
    .wb_data         (wb_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [RADDR-1:0] d,
                       input logic w, input logic m);
    issue_valid = v;
    issue_dst   = d;
    issue_wen   = w;
    issue_ismem = m;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [RADDR+WIDTH-1:0] e;
    if (resetn && wb_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got dst=%0d data=%h, required no write-back",
                 wb_dst, wb_data);
      end else begin
        e = exp_q.pop_front();
        if ({wb_dst, wb_data} !== e) begin
          n_err++;
          $display("FAIL wb_data: got dst=%0d data=%h, required dst=%0d data=%h",
                   wb_dst, wb_data, e[WIDTH+RADDR-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    resetn          = 1'b0;
    offer(1'b0, '0, 1'b0, 1'b0);
    flush           = 1'b0;
    exe_result      = '0;
    mem_rdata       = '0;
    mem_rdata_valid = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_validE", validE, 0);
    chk("rst_validM", validM, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_rdM", rdM, 0);
    chk("rst_wb_data", wb_data, 0);
    #3 resetn = 1'b1;
    cyc();

    // case 1: plain ALU op to r3; mem_rdata_valid while M is not waiting
    offer(1'b1, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("c1_ready", issue_ready, 1);
    exp_q.push_back({5'd3, 64'h11});
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    exe_result = 64'h11;
    @(negedge clk);
    chk("c1_validE", validE, 1);
    chk("c1_dstE", dstE, 3);
    chk("c1_rdE", rdE, 64'h11);
    chk("c1_validM_early", validM, 0);
    cyc();
    exe_result      = '0;
    mem_rdata_valid = 1'b1;
    mem_rdata       = 64'hdead;
    @(negedge clk);
    chk("c1_validE_off", validE, 0);
    chk("c1_validM", validM, 1);
    chk("c1_dstM", dstM, 3);
    chk("c1_rdM", rdM, 64'h11);
    cyc();
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    @(negedge clk);
    chk("c1_wb_valid", wb_valid, 1);
    chk("c1_validM_off", validM, 0);
    cyc();
    @(negedge clk);
    chk("c1_idle_wb_valid", wb_valid, 0);
    chk("c1_idle_wb_dst", wb_dst, 0);
    chk("c1_idle_wb_data", wb_data, 0);
    chk("c1_idle_rdM", rdM, 0);
    cyc();

    // case 2: load to r5 waits 3 cycles, second instruction offered meanwhile
    offer(1'b1, 5'd5, 1'b1, 1'b1);
    exp_q.push_back({5'd5, 64'hab});
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    exe_result = 64'h99;
    @(negedge clk);
    chk("c2_validE", validE, 1);
    chk("c2_ismemE", ismemE, 1);
    cyc();
    exe_result = '0;
    offer(1'b1, 5'd9, 1'b1, 1'b0);
    mem_rdata  = 64'hee;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("c2_wait_ready", issue_ready, 0);
      chk("c2_wait_validM", validM, 0);
      chk("c2_wait_validE", validE, 0);
      if (k == 3) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = 64'hab;
      end
      cyc();
    end
    mem_rdata_valid = 1'b0;
    mem_rdata       = 64'hee;
    @(negedge clk);
    chk("c2_validM", validM, 1);
    chk("c2_dstM", dstM, 5);
    chk("c2_rdM", rdM, 64'hab);
    chk("c2_ready", issue_ready, 1);
    chk("c2_second_not_in_E", validE, 0);
    exp_q.push_back({5'd9, 64'h22});
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    exe_result = 64'h22;
    @(negedge clk);
    chk("c2_second_validE", validE, 1);
    chk("c2_second_dstE", dstE, 9);
    chk("c2_validM_left", validM, 0);
    cyc();
    exe_result = '0;
    @(negedge clk);
    chk("c2_second_rdM", rdM, 64'h22);
    cyc();
    cyc();

    // case 3: write to r0 is never forwarded nor retired
    offer(1'b1, 5'd0, 1'b1, 1'b0);
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    exe_result = 64'h30;
    @(negedge clk);
    chk("c3_validE", validE, 0);
    cyc();
    exe_result = '0;
    @(negedge clk);
    chk("c3_validM", validM, 0);
    cyc();
    @(negedge clk);
    chk("c3_wb_valid", wb_valid, 0);
    cyc();

    // case 4: flush with a simultaneous issue while E holds r7
    offer(1'b1, 5'd7, 1'b1, 1'b0);
    cyc();
    offer(1'b1, 5'd8, 1'b1, 1'b0);
    flush      = 1'b1;
    exe_result = 64'h70;
    @(negedge clk);
    chk("c4_ready", issue_ready, 0);
    chk("c4_validE_before", validE, 1);
    chk("c4_dstE_before", dstE, 7);
    cyc();
    flush      = 1'b0;
    exe_result = '0;
    offer(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("c4_validE", validE, 0);
    chk("c4_validM", validM, 0);
    cyc();
    @(negedge clk);
    chk("c4_wb_valid", wb_valid, 0);
    cyc();
    cyc();

    // case 5: flush during a load wait; load to r4 still completes
    offer(1'b1, 5'd4, 1'b1, 1'b1);
    exp_q.push_back({5'd4, 64'h5a});
    cyc();
    offer(1'b1, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    chk("c5_ready_before", issue_ready, 1);
    chk("c5_ismemE", ismemE, 1);
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    flush      = 1'b1;
    exe_result = 64'h66;
    @(negedge clk);
    chk("c5_validE", validE, 1);
    chk("c5_dstE", dstE, 6);
    chk("c5_ready", issue_ready, 0);
    chk("c5_validM_wait", validM, 0);
    cyc();
    flush      = 1'b0;
    exe_result = '0;
    @(negedge clk);
    chk("c5_validE_flushed", validE, 0);
    chk("c5_still_waiting", issue_ready, 0);
    mem_rdata_valid = 1'b1;
    mem_rdata       = 64'h5a;
    cyc();
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    @(negedge clk);
    chk("c5_validM", validM, 1);
    chk("c5_rdM", rdM, 64'h5a);
    chk("c5_dstM", dstM, 4);
    cyc();
    cyc();
    cyc();

    // case 6: reset in the middle of a load wait, then normal flow
    offer(1'b1, 5'd2, 1'b1, 1'b1);
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    cyc();
    @(negedge clk);
    chk("c6_waiting", issue_ready, 0);
    cyc();
    #2 resetn = 1'b0;
    #1;
    chk("c6_async_validM", validM, 0);
    chk("c6_async_dstM", dstM, 0);
    chk("c6_async_ready", issue_ready, 1);
    chk("c6_async_wb_valid", wb_valid, 0);
    chk("c6_async_validE", validE, 0);
    mem_rdata_valid = 1'b1;
    mem_rdata       = 64'h33;
    cyc();
    cyc();
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    #3 resetn = 1'b1;
    cyc();
    @(negedge clk);
    chk("c6_post_validM", validM, 0);
    chk("c6_post_wb_valid", wb_valid, 0);
    offer(1'b1, 5'd12, 1'b1, 1'b0);
    exp_q.push_back({5'd12, 64'h77});
    cyc();
    offer(1'b0, '0, 1'b0, 1'b0);
    exe_result = 64'h77;
    @(negedge clk);
    chk("c6_validE", validE, 1);
    chk("c6_dstE", dstE, 12);
    cyc();
    exe_result = '0;
    @(negedge clk);
    chk("c6_validM", validM, 1);
    chk("c6_rdM", rdM, 64'h77);
    cyc();
    @(negedge clk);
    chk("c6_wb_valid", wb_valid, 1);
    repeat (4) cyc();

    // final report
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // safety bound on total run time
  initial begin
    #20000;
    $display("FAIL timeout: got no end of stimulus, required completion within 20000 time units");
    $fatal(1);
  end

endmodule : tb_fwd_pipe
